// File: rtl/MD_pkg.sv
// MD_pkg: shared definitions for the pair-selection stage.
//  - Default width constants for neighbour packet, node id and home particle id.
//  - pair_sel_t: the selected-pair record at the default widths.
//  - onehot2idx: encode a one-hot vector (up to OH_MAX bits) into its bit index.
package MD_pkg;

  localparam int unsigned POS_PKT_STRUCT_WIDTH = 16;
  localparam int unsigned NODE_ID_WIDTH        = 8;
  localparam int unsigned PARTICLE_ID_WIDTH    = 12;

  // Widest one-hot vector onehot2idx accepts.
  localparam int unsigned OH_MAX = 64;

  typedef struct packed {
    logic [POS_PKT_STRUCT_WIDTH-1:0] nb;
    logic [NODE_ID_WIDTH-1:0]        node_id;
    logic [PARTICLE_ID_WIDTH-1:0]    home_parid;
  } pair_sel_t;

  // OR of the indices of all set bits; exact for a one-hot input, 0 for all-zero.
  function automatic int unsigned onehot2idx(input logic [OH_MAX-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < OH_MAX; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-of-N arbiter, round-robin (MODE=0) or fixed priority (MODE=1).
// Ports:
//  clk, rst    clock, synchronous active-high reset
//  req         request vector
//  advance     grant permitted this cycle; grant is all-zero when low
//  grant       one-hot grant (combinational)
//  grant_idx   index of the granted bit (0 when no grant)
// The round-robin pointer moves to grant_idx+1 (mod N) only on an actual grant.
module rr_arbiter
  import MD_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned MODE = 0,
  localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr;
  logic [N-1:0]  pick;

  always_comb begin
    logic        found;
    int unsigned k;
    pick  = '0;
    found = 1'b0;
    k     = 0;
    if (MODE == 1) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && req[i]) begin
          pick[i] = 1'b1;
          found   = 1'b1;
        end
      end
    end else begin
      // Scan N positions starting at ptr, wrapping past N-1 back to 0.
      for (int unsigned off = 0; off < N; off++) begin
        k = int'(ptr) + off;
        if (k >= N) k = k - N;
        if (!found && req[k]) begin
          pick[k] = 1'b1;
          found   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant     = advance ? pick : '0;
    grant_idx = IW'(onehot2idx(OH_MAX'(grant)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (MODE == 0 && |grant) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/pair_select_rr.sv
// pair_select_rr: arbitrates among NUM_CH filter output channels, pops the
// granted channel, registers its pair and holds it until the force pipeline
// accepts it.
// Ports:
//  clk, rst                 clock, synchronous active-high reset
//  i_ch_valid               per-channel "holds a pair"
//  i_ch_nb/node_id/home_parid  per-channel packed data, channel k at [k*W +: W]
//  o_ch_pop                 one-hot pop, combinational, 0 during reset
//  i_pair_ready             downstream accepts the held pair this cycle
//  o_*_selected             registered pair
//  o_pair_selected_valid    output register holds a pair
//  o_grant_idx              channel index of the held pair
//  o_pair_count             pairs accepted downstream (wraps)
module pair_select_rr
  import MD_pkg::*;
#(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned NB_W     = POS_PKT_STRUCT_WIDTH,
  parameter int unsigned NODE_W   = NODE_ID_WIDTH,
  parameter int unsigned PID_W    = PARTICLE_ID_WIDTH,
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned CNT_W    = 32,
  localparam int unsigned IDX_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        i_ch_valid,
  input  logic [NUM_CH*NB_W-1:0]   i_ch_nb,
  input  logic [NUM_CH*NODE_W-1:0] i_ch_node_id,
  input  logic [NUM_CH*PID_W-1:0]  i_ch_home_parid,
  output logic [NUM_CH-1:0]        o_ch_pop,
  input  logic                     i_pair_ready,
  output logic [NB_W-1:0]          o_nb_selected,
  output logic [NODE_W-1:0]        o_node_id_selected,
  output logic [PID_W-1:0]         o_home_selected_parid,
  output logic                     o_pair_selected_valid,
  output logic [IDX_W-1:0]         o_grant_idx,
  output logic [CNT_W-1:0]         o_pair_count
);

  // Same layout as pair_sel_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [NB_W-1:0]   nb;
    logic [NODE_W-1:0] node_id;
    logic [PID_W-1:0]  home_parid;
  } pair_reg_t;

  pair_reg_t        held;
  logic             held_valid;
  logic [IDX_W-1:0] held_idx;
  logic             free;
  logic [IDX_W-1:0] gnt_idx;
  logic             any_grant;
  logic             accept;

  assign free   = !held_valid || i_pair_ready;
  assign accept = held_valid && i_pair_ready;

  rr_arbiter #(
    .N    (NUM_CH),
    .MODE (ARB_MODE)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (i_ch_valid),
    .advance   (free && !rst),
    .grant     (o_ch_pop),
    .grant_idx (gnt_idx)
  );

  assign any_grant = |o_ch_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      held       <= '0;
      held_valid <= 1'b0;
      held_idx   <= '0;
    end else if (any_grant) begin
      held.nb         <= i_ch_nb[gnt_idx*NB_W +: NB_W];
      held.node_id    <= i_ch_node_id[gnt_idx*NODE_W +: NODE_W];
      held.home_parid <= i_ch_home_parid[gnt_idx*PID_W +: PID_W];
      held_idx        <= gnt_idx;
      held_valid      <= 1'b1;
    end else if (free) begin
      held_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_pair_count <= '0;
    end else if (accept) begin
      o_pair_count <= o_pair_count + 1'b1;
    end
  end

  assign o_nb_selected         = held.nb;
  assign o_node_id_selected    = held.node_id;
  assign o_home_selected_parid = held.home_parid;
  assign o_pair_selected_valid = held_valid;
  assign o_grant_idx           = held_idx;

endmodule

// File: tb/tb_pair_select_rr.sv
// Directed testbench for pair_select_rr: instance u_rr (round-robin, 4-bit
// counter) and instance u_fp (fixed priority) share all inputs.
module tb_pair_select_rr;

  localparam int unsigned NCH  = 8;
  localparam int unsigned NBW  = 16;
  localparam int unsigned NDW  = 8;
  localparam int unsigned PIDW = 12;
  localparam int unsigned CW   = 4;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    ch_valid;
  logic [NCH*NBW-1:0]  ch_nb;
  logic [NCH*NDW-1:0]  ch_node;
  logic [NCH*PIDW-1:0] ch_pid;
  logic              ready;

  logic [NCH-1:0]    pop_a, pop_b;
  logic [NBW-1:0]    nb_a, nb_b;
  logic [NDW-1:0]    node_a, node_b;
  logic [PIDW-1:0]   pid_a, pid_b;
  logic              val_a, val_b;
  logic [2:0]        idx_a, idx_b;
  logic [CW-1:0]     cnt_a, cnt_b;

  int unsigned n_vec;
  int unsigned n_miscmp;

  pair_select_rr #(
    .NUM_CH(NCH), .NB_W(NBW), .NODE_W(NDW), .PID_W(PIDW), .ARB_MODE(0), .CNT_W(CW)
  ) u_rr (
    .clk(clk), .rst(rst), .i_ch_valid(ch_valid), .i_ch_nb(ch_nb),
    .i_ch_node_id(ch_node), .i_ch_home_parid(ch_pid), .o_ch_pop(pop_a),
    .i_pair_ready(ready), .o_nb_selected(nb_a), .o_node_id_selected(node_a),
    .o_home_selected_parid(pid_a), .o_pair_selected_valid(val_a),
    .o_grant_idx(idx_a), .o_pair_count(cnt_a)
  );

  pair_select_rr #(
    .NUM_CH(NCH), .NB_W(NBW), .NODE_W(NDW), .PID_W(PIDW), .ARB_MODE(1), .CNT_W(CW)
  ) u_fp (
    .clk(clk), .rst(rst), .i_ch_valid(ch_valid), .i_ch_nb(ch_nb),
    .i_ch_node_id(ch_node), .i_ch_home_parid(ch_pid), .o_ch_pop(pop_b),
    .i_pair_ready(ready), .o_nb_selected(nb_b), .o_node_id_selected(node_b),
    .o_home_selected_parid(pid_b), .o_pair_selected_valid(val_b),
    .o_grant_idx(idx_b), .o_pair_count(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec    = 0;
    n_miscmp = 0;
    rst      = 1'b1;
    ch_valid = '1;
    ready    = 1'b0;
    // Channel k data: nb = A000+k, node = 10+k, pid = 300+k.
    for (int unsigned k = 0; k < NCH; k++) begin
      ch_nb[k*NBW +: NBW]    = NBW'(16'hA000 + k);
      ch_node[k*NDW +: NDW]  = NDW'(8'h10 + k);
      ch_pid[k*PIDW +: PIDW] = PIDW'(12'h300 + k);
    end

    // 1. reset with every channel requesting
    repeat (3) step();
    check_eq("rst_pop",   64'(pop_a), 64'h0);
    check_eq("rst_valid", 64'(val_a), 64'h0);
    check_eq("rst_count", 64'(cnt_a), 64'h0);
    check_eq("rst_idx",   64'(idx_a), 64'h0);
    check_eq("rst_fp_pop", 64'(pop_b), 64'h0);
    rst = 1'b0;
    #1;
    check_eq("rel_pop", 64'(pop_a), 64'h01);

    // 2. round-robin fairness, all valid, ready high
    ready = 1'b1;
    for (int unsigned i = 0; i < 9; i++) begin
      check_eq("rr_pop", 64'(pop_a), 64'(8'h01 << (i % 8)));
      step();
      check_eq("rr_idx", 64'(idx_a), 64'(i % 8));
      check_eq("rr_nb",  64'(nb_a), 64'(16'hA000 + (i % 8)));
      check_eq("rr_val", 64'(val_a), 64'h1);
    end
    ch_valid = '0;
    step();
    check_eq("rr_count9", 64'(cnt_a), 64'd9);
    check_eq("rr_drain",  64'(val_a), 64'h0);

    // 3. backpressure on ch3
    ready    = 1'b0;
    ch_valid = 8'h08;
    #1;
    check_eq("bp_pop1", 64'(pop_a), 64'h08);
    step();
    check_eq("bp_val", 64'(val_a), 64'h1);
    check_eq("bp_idx", 64'(idx_a), 64'd3);
    repeat (5) begin
      step();
      check_eq("bp_hold_pop",  64'(pop_a),  64'h0);
      check_eq("bp_hold_nb",   64'(nb_a),   64'hA003);
      check_eq("bp_hold_node", 64'(node_a), 64'h13);
      check_eq("bp_hold_pid",  64'(pid_a),  64'h303);
      check_eq("bp_hold_val",  64'(val_a),  64'h1);
    end
    check_eq("bp_hold_cnt", 64'(cnt_a), 64'd9);
    ready = 1'b1;
    #1;
    check_eq("bp_pop2", 64'(pop_a), 64'h08);
    step();
    check_eq("bp_cnt10", 64'(cnt_a), 64'd10);
    check_eq("bp_idx2",  64'(idx_a), 64'd3);
    ch_valid = '0;
    step();
    check_eq("bp_cnt11", 64'(cnt_a), 64'd11);
    check_eq("bp_drain", 64'(val_a), 64'h0);

    // 4. wrap and skip: grant ch5 to put ptr at 6, then ch1|ch7
    ch_valid = 8'h20;
    #1;
    check_eq("wr_pop5", 64'(pop_a), 64'h20);
    step();
    ch_valid = 8'h82;
    #1;
    check_eq("wr_pop7", 64'(pop_a), 64'h80);
    step();
    check_eq("wr_idx7", 64'(idx_a), 64'd7);
    check_eq("wr_cnt12", 64'(cnt_a), 64'd12);
    check_eq("wr_pop1", 64'(pop_a), 64'h02);
    step();
    check_eq("wr_idx1", 64'(idx_a), 64'd1);
    check_eq("wr_nb1",  64'(nb_a),  64'hA001);
    check_eq("wr_cnt13", 64'(cnt_a), 64'd13);

    // 5. fixed priority: ch2 and ch5 continuously
    ch_valid = 8'h24;
    #1;
    repeat (4) begin
      check_eq("fp_pop", 64'(pop_b), 64'h04);
      step();
      check_eq("fp_idx", 64'(idx_b), 64'd2);
      check_eq("fp_val", 64'(val_b), 64'h1);
    end

    // reset while a pair is held
    check_eq("mr_val_pre", 64'(val_a), 64'h1);
    rst = 1'b1;
    #1;
    check_eq("mr_pop", 64'(pop_a), 64'h0);
    step();
    check_eq("mr_val", 64'(val_a), 64'h0);
    check_eq("mr_cnt", 64'(cnt_a), 64'h0);
    check_eq("mr_fp_val", 64'(val_b), 64'h0);

    // 6. counter wrap: one capture then 17 accepts on a 4-bit counter
    rst      = 1'b0;
    ch_valid = '1;
    ready    = 1'b1;
    repeat (18) step();
    check_eq("cw_cnt", 64'(cnt_a), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
